// File: rtl/fetch.sv
// fetch: instruction-fetch PC register; advances by 4 or loads a branch target each cycle.
module fetch #(
    parameter int N = 64
) (
    input  logic         PCSrc_F,
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PCBranch_F,
    output logic [N-1:0] imem_addr_F
);
    logic [N-1:0] pc_q, pc_d, pc_plus4;
    always_comb begin
        pc_plus4 = pc_q + N'(4);
        pc_d     = PCSrc_F ? PCBranch_F : pc_plus4;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= '0;
        else        pc_q <= pc_d;
    end
    assign imem_addr_F = pc_q;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for fetch; expected PCs are queued at each edge and checked 1 ns after it.
module tb_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCSrc_F = 1'b0;
    logic [63:0] PCBranch_F = '0;
    logic [63:0] imem_addr_F;
    logic [63:0] exp_q[$];
    logic [63:0] model_pc = '0;
    logic [63:0] e;
    int          vectors = 0;
    int          miscompares = 0;

    fetch #(.N(64)) dut (
        .PCSrc_F(PCSrc_F), .clk(clk), .reset(reset),
        .PCBranch_F(PCBranch_F), .imem_addr_F(imem_addr_F)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference model advances on the edge and queues the value the DUT must show after it.
    task automatic tick();
        model_pc = !reset ? 64'h0 : (PCSrc_F ? PCBranch_F : model_pc + 64'd4);
        exp_q.push_back(model_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        PCSrc_F = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (imem_addr_F !== e) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, imem_addr_F, e);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (imem_addr_F !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", imem_addr_F, 64'h0);
        end
    endtask

    task automatic test_sequential();
        PCSrc_F = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (imem_addr_F !== e) begin
                miscompares++;
                $display("FAIL sequential[%0d]: got %h expected %h", i, imem_addr_F, e);
            end
        end
    endtask

    task automatic test_branch();
        PCBranch_F = 64'd16;
        PCSrc_F = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (imem_addr_F !== e) begin
                miscompares++;
                $display("FAIL branch_hold[%0d]: got %h expected %h", i, imem_addr_F, e);
            end
        end
    endtask

    task automatic test_branch_then_seq();
        PCBranch_F = 64'h1000;
        PCSrc_F = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            PCSrc_F = 1'b0;
            PCBranch_F = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            e = exp_q.pop_front();
            vectors++;
            if (imem_addr_F !== e) begin
                miscompares++;
                $display("FAIL branch_seq[%0d]: got %h expected %h", i, imem_addr_F, e);
            end
        end
    endtask

    task automatic test_async_reset();
        PCBranch_F = 64'h20;
        PCSrc_F = 1'b1;
        tick();
        e = exp_q.pop_front();
        vectors++;
        if (imem_addr_F !== e) begin
            miscompares++;
            $display("FAIL async_setup: got %h expected %h", imem_addr_F, e);
        end
        PCSrc_F = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (imem_addr_F !== 64'h0) begin
            miscompares++;
            $display("FAIL async_midcycle: got %h expected %h", imem_addr_F, 64'h0);
        end
        model_pc = 64'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (imem_addr_F !== e) begin
                miscompares++;
                $display("FAIL async_hold[%0d]: got %h expected %h", i, imem_addr_F, e);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        e = exp_q.pop_front();
        vectors++;
        if (imem_addr_F !== e) begin
            miscompares++;
            $display("FAIL async_release: got %h expected %h", imem_addr_F, e);
        end
    endtask

    task automatic test_wrap();
        PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
        PCSrc_F = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            PCSrc_F = 1'b0;
            PCBranch_F = 'x;
            e = exp_q.pop_front();
            vectors++;
            if (imem_addr_F !== e) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, imem_addr_F, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        PCSrc_F = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PCBranch_F = 64'h4000_0000 + 64'($urandom_range(0, 1023));
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (imem_addr_F !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, imem_addr_F, e);
            end
        end
        PCSrc_F = 1'b0;
        tick();
        e = exp_q.pop_front();
        vectors++;
        if (imem_addr_F !== e) begin
            miscompares++;
            $display("FAIL back_to_back_seq: got %h expected %h", imem_addr_F, e);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_branch_then_seq();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d expected %0d", exp_q.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the pipelined 64-bit processor. Holds the program counter (PC) and drives it out as the instruction-memory address. Every cycle it either advances sequentially (PC+4) or loads a branch target supplied by a later stage. The block is built from three internal parts: a PC register with asynchronous reset, a 64-bit +4 adder and a 2:1 next-PC multiplexer.

## Interface

Parameters:
- N, default 64: PC / address width in bits. All arithmetic is N-bit.

Ports, positional order fixed as PCSrc_F, clk, reset, PCBranch_F, imem_addr_F:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset = 0 clears the PC immediately. reset = 1 is normal operation.
- PCSrc_F  input  1  next-PC select: 0 selects PC+4, 1 selects PCBranch_F.
- PCBranch_F  input  N  branch/jump target address.
- imem_addr_F  output  N  current PC, fed directly to instruction memory.

## Operation

- Internal state is one N-bit register, PC.
- imem_addr_F = PC, driven combinationally from the register with no extra logic.
- Next-PC logic:
  - PCPlus4 = PC + 4, computed modulo 2^N; carry-out is discarded.
  - next_PC = PCSrc_F ? PCBranch_F : PCPlus4.
- On each rising clk edge with reset = 1: PC <= next_PC.
- Whenever reset = 0: PC = 0, independent of clk. While reset stays low, rising edges are ignored.
- Reset value of imem_addr_F is 64'h0.
- PCBranch_F is loaded verbatim. Alignment is neither checked nor forced.
- PCSrc_F and PCBranch_F are sampled only at the rising edge. Between edges they are don't-care and have no effect on imem_addr_F.
- Wrap-around: PC = 2^N−4 with PCSrc_F = 0 gives next PC = 0.
- X/undefined PCBranch_F while PCSrc_F = 0 must not affect the PC.

## Timing

- Latency is 1 cycle: a next_PC computed in cycle k appears on imem_addr_F just after the rising edge ending cycle k (clock-to-q only).
- Reset assertion is asynchronous: imem_addr_F goes to 0 within one propagation delay of reset falling, mid-cycle included.
- Reset release:
  - The PC holds 0 until the first rising edge with reset = 1.
  - On that edge the PC becomes 4 if PCSrc_F = 0, or PCBranch_F if PCSrc_F = 1.
  - Consecutive edges then give 8, 12, 16, … .
- Reset deasserted coincident with a rising edge: that edge is treated as a reset edge and the PC stays 0. Benches release reset away from rising edges, e.g. at the falling edge.
- PCSrc_F held at 1 across several edges reloads PCBranch_F on every edge.
- There is no stall, enable or handshake. The PC advances every cycle.

## Test plan

- Reset hold: reset = 0 for 5 cycles with PCSrc_F = 0 -> imem_addr_F = 0 at every check, including immediately after reset is released at a falling edge.
- Sequential fetch: release reset, PCSrc_F = 0 -> imem_addr_F = 4, 8, 12, 16, 20 after the 1st–5th rising edges, each checked 1 ns after the edge.
- Branch load: after PC = 20, set PCBranch_F = 16 and PCSrc_F = 1 -> imem_addr_F = 16 after the next rising edge. It stays 16 on subsequent edges while PCSrc_F = 1.
- Branch then sequential: PCBranch_F = 0x1000, PCSrc_F = 1 for one edge, then PCSrc_F = 0 -> 0x1000, 0x1004, 0x1008.
- Asynchronous reset mid-operation: PC = 0x20, pull reset low midway between edges -> imem_addr_F = 0 before the next edge. It remains 0 on edges while reset is low.
- Wrap-around: PCBranch_F = 0xFFFF_FFFF_FFFF_FFFC loaded, then PCSrc_F = 0 -> next edge gives imem_addr_F = 0, then 4.
